// File: rtl/l1_lru_cache_main.sv
// L1 set-associative cache simulator with true-LRU replacement.
// A built-in address generator replays a fixed read trace against the tag
// store and counts hits, misses and evictions.
// Optional build macro MAIN_TRACE_EN: prints one line per access and a final
// summary; cycle behaviour and outputs are the same either way.
module l1_lru_cache_main #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned OFFSET_BITS = 2,
  parameter int unsigned NUM_SETS    = 4,
  parameter int unsigned WAYS        = 2,
  parameter int unsigned TRACE_LEN   = 32,
  parameter int unsigned PATTERN     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [15:0]               hit_count,
  output logic [15:0]               miss_count,
  output logic [15:0]               evict_count,
  output logic [15:0]               access_count,
  output logic                      last_hit,
  output logic [$clog2(WAYS)-1:0]   last_way,
  output logic                      done
);

  localparam int unsigned INDEX_BITS = $clog2(NUM_SETS);
  // A single-set cache has no index field; keep a 1-bit index that is always 0.
  localparam int unsigned IDX_W      = (INDEX_BITS > 0) ? INDEX_BITS : 1;
  localparam int unsigned TAG_W      = ADDR_W - OFFSET_BITS - INDEX_BITS;
  localparam int unsigned WAY_W      = $clog2(WAYS);
  localparam int unsigned CNT_W      = $clog2(TRACE_LEN + 1);
  localparam int unsigned PIDX_W     = $clog2(PATTERN + 1);

  typedef enum logic [1:0] {StIdle, StLookup, StUpdate, StDone} state_e;

  state_e              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_i;
  logic [PIDX_W-1:0]   r_pidx;   // i mod PATTERN, tracked incrementally
  logic                r_valid [NUM_SETS][WAYS];
  logic [TAG_W-1:0]    r_tag   [NUM_SETS][WAYS];
  logic [WAY_W-1:0]    r_age   [NUM_SETS][WAYS];
  logic                r_hit, r_evict;
  logic [WAY_W-1:0]    r_way;
  logic [15:0]         r_hits, r_misses, r_evicts, r_accesses;
  logic                r_last_hit, r_done;
  logic [WAY_W-1:0]    r_last_way;

  logic [ADDR_W-1:0]   w_addr;
  logic [IDX_W-1:0]    w_index;
  logic [TAG_W-1:0]    w_tag;
  logic                w_hit, w_vic_found;
  logic [WAY_W-1:0]    w_hit_way, w_vic_way, w_lru_way;
  logic                w_last_access;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_addr        = ADDR_W'(r_pidx) << OFFSET_BITS;
  assign w_index       = IDX_W'((w_addr >> OFFSET_BITS) & ADDR_W'(NUM_SETS - 1));
  assign w_tag         = TAG_W'(w_addr >> (OFFSET_BITS + INDEX_BITS));
  assign w_last_access = (r_i == CNT_W'(TRACE_LEN - 1));

  // Tag compare, lowest invalid way and LRU way of the addressed set.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_vic_found = 1'b0;
    w_vic_way   = '0;
    w_lru_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_index][w] && (r_tag[w_index][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!r_valid[w_index][w] && !w_vic_found) begin
        w_vic_found = 1'b1;
        w_vic_way   = WAY_W'(w);
      end
      if (r_age[w_index][w] == WAY_W'(WAYS - 1)) w_lru_way = WAY_W'(w);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   w_state_nxt = StLookup;
      StLookup: w_state_nxt = StUpdate;
      StUpdate: w_state_nxt = w_last_access ? StDone : StLookup;
      StDone:   w_state_nxt = StDone;
      default:  w_state_nxt = StIdle;
    endcase
  end

  // Tag store, LRU ages, trace position and statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_tag[s][w]   <= '0;
          r_age[s][w]   <= WAY_W'(w);
        end
      end
      r_i        <= '0;
      r_pidx     <= '0;
      r_hit      <= 1'b0;
      r_evict    <= 1'b0;
      r_way      <= '0;
      r_hits     <= '0;
      r_misses   <= '0;
      r_evicts   <= '0;
      r_accesses <= '0;
      r_last_hit <= 1'b0;
      r_last_way <= '0;
      r_done     <= 1'b0;
    end else begin
      if (r_state == StLookup) begin
        r_hit   <= w_hit;
        r_way   <= w_hit ? w_hit_way : (w_vic_found ? w_vic_way : w_lru_way);
        r_evict <= !w_hit && !w_vic_found;
      end
      if (r_state == StUpdate) begin
        if (!r_hit) begin
          r_valid[w_index][r_way] <= 1'b1;
          r_tag[w_index][r_way]   <= w_tag;
        end
        // Ways younger than the accessed one age by one; accessed way becomes MRU.
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == r_way) begin
            r_age[w_index][w] <= '0;
          end else if (r_age[w_index][w] < r_age[w_index][r_way]) begin
            r_age[w_index][w] <= r_age[w_index][w] + 1'b1;
          end
        end
        if (r_hit) r_hits   <= sat_inc(r_hits);
        else       r_misses <= sat_inc(r_misses);
        if (r_evict) r_evicts <= sat_inc(r_evicts);
        r_accesses <= sat_inc(r_accesses);
        r_last_hit <= r_hit;
        r_last_way <= r_way;
        r_i        <= r_i + 1'b1;
        r_pidx     <= (r_pidx == PIDX_W'(PATTERN - 1)) ? '0 : r_pidx + 1'b1;
        if (w_last_access) r_done <= 1'b1;
      end
    end
  end

`ifdef MAIN_TRACE_EN
  // Per-access trace line and end-of-run totals.
  always @(posedge clk) begin
    if (!reset && r_state == StUpdate) begin
      $display("i=%0d addr=0x%0h set=%0d tag=0x%0h %s way=%0d%s", r_i, w_addr, w_index, w_tag,
               r_hit ? "HIT" : "MISS", r_way, r_evict ? " EVICT" : "");
      if (w_last_access) begin
        $display("trace done: hits=%0d misses=%0d evictions=%0d",
                 r_hits + {15'd0, r_hit}, r_misses + {15'd0, !r_hit},
                 r_evicts + {15'd0, r_evict});
      end
    end
  end
`endif

  assign hit_count    = r_hits;
  assign miss_count   = r_misses;
  assign evict_count  = r_evicts;
  assign access_count = r_accesses;
  assign last_hit     = r_last_hit;
  assign last_way     = r_last_way;
  assign done         = r_done;

endmodule

// File: tb/tb_l1_lru_cache_main.sv
// Directed bench for l1_lru_cache_main: four parameterisations run in
// lockstep from one clock and reset, checked against hand-computed totals.
module tb_l1_lru_cache_main;

  logic clk;
  logic reset;

  logic [15:0] d_hit, d_miss, d_evict, d_acc;
  logic        d_lhit, d_done;
  logic [0:0]  d_lway;

  logic [15:0] a_hit, a_miss, a_evict, a_acc;
  logic        a_lhit, a_done;
  logic [0:0]  a_lway;

  logic [15:0] b_hit, b_miss, b_evict, b_acc;
  logic        b_lhit, b_done;
  logic [1:0]  b_lway;

  logic [15:0] s_hit, s_miss, s_evict, s_acc;
  logic        s_lhit, s_done;
  logic [0:0]  s_lway;

  int n_vec;
  int n_err;

  // Defaults: 4 sets x 2 ways, PATTERN 8.
  l1_lru_cache_main u_dflt (
    .clk          (clk),
    .reset        (reset),
    .hit_count    (d_hit),
    .miss_count   (d_miss),
    .evict_count  (d_evict),
    .access_count (d_acc),
    .last_hit     (d_lhit),
    .last_way     (d_lway),
    .done         (d_done)
  );

  // PATTERN 12, 2 ways: three tags per set thrash.
  l1_lru_cache_main #(.PATTERN(12)) u_p12 (
    .clk          (clk),
    .reset        (reset),
    .hit_count    (a_hit),
    .miss_count   (a_miss),
    .evict_count  (a_evict),
    .access_count (a_acc),
    .last_hit     (a_lhit),
    .last_way     (a_lway),
    .done         (a_done)
  );

  // PATTERN 12, 4 ways: three tags per set fit.
  l1_lru_cache_main #(.PATTERN(12), .WAYS(4)) u_p12w4 (
    .clk          (clk),
    .reset        (reset),
    .hit_count    (b_hit),
    .miss_count   (b_miss),
    .evict_count  (b_evict),
    .access_count (b_acc),
    .last_hit     (b_lhit),
    .last_way     (b_lway),
    .done         (b_done)
  );

  // One set, 2 ways, PATTERN 3.
  l1_lru_cache_main #(.NUM_SETS(1), .WAYS(2), .PATTERN(3)) u_s1 (
    .clk          (clk),
    .reset        (reset),
    .hit_count    (s_hit),
    .miss_count   (s_miss),
    .evict_count  (s_evict),
    .access_count (s_acc),
    .last_hit     (s_lhit),
    .last_way     (s_lway),
    .done         (s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then sample 1 time unit later.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_dflt_final(input string pfx);
    check_val({pfx, " miss"},  32'(d_miss),  32'd8);
    check_val({pfx, " hit"},   32'(d_hit),   32'd24);
    check_val({pfx, " evict"}, 32'(d_evict), 32'd0);
    check_val({pfx, " acc"},   32'(d_acc),   32'd32);
    check_val({pfx, " done"},  32'(d_done),  32'd1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;

    // Reset held for 3 cycles.
    step(3);
    check_val("rst hit",   32'(d_hit),   32'd0);
    check_val("rst miss",  32'(d_miss),  32'd0);
    check_val("rst evict", 32'(d_evict), 32'd0);
    check_val("rst acc",   32'(d_acc),   32'd0);
    check_val("rst done",  32'(d_done),  32'd0);
    check_val("rst lhit",  32'(d_lhit),  32'd0);
    check_val("rst lway",  32'(d_lway),  32'd0);

    @(negedge clk);
    reset = 1'b0;

    // Edge 3: access 0 (set 0, tag 0) misses into way 0.
    step(3);
    check_val("e3 acc",   32'(d_acc),  32'd1);
    check_val("e3 miss",  32'(d_miss), 32'd1);
    check_val("e3 lway",  32'(d_lway), 32'd0);
    check_val("e3 lhit",  32'(d_lhit), 32'd0);
    // Edge 5: single-set cache fills way 1 with tag 1.
    step(2);
    check_val("s1 e5 lway", 32'(s_lway), 32'd1);
    check_val("s1 e5 evict", 32'(s_evict), 32'd0);
    // Edge 7: tag 2 evicts LRU way 0 (tag 0).
    step(2);
    check_val("s1 e7 lway",  32'(s_lway),  32'd0);
    check_val("s1 e7 evict", 32'(s_evict), 32'd1);
    check_val("s1 e7 lhit",  32'(s_lhit),  32'd0);
    // 10 edges after release: 4 accesses complete.
    step(3);
    check_val("e10 acc", 32'(d_acc), 32'd4);
    // Edge 11: access 4 (set 0, tag 1) misses into invalid way 1.
    step(1);
    check_val("e11 lway", 32'(d_lway), 32'd1);
    check_val("e11 lhit", 32'(d_lhit), 32'd0);
    check_val("e11 miss", 32'(d_miss), 32'd5);
    // Edge 19: access 8 (set 0, tag 0) hits way 0.
    step(8);
    check_val("e19 lhit", 32'(d_lhit), 32'd1);
    check_val("e19 lway", 32'(d_lway), 32'd0);
    // Edge 27: access 12 (set 0, tag 1) hits way 1.
    step(8);
    check_val("e27 lhit", 32'(d_lhit), 32'd1);
    check_val("e27 lway", 32'(d_lway), 32'd1);
    // Edge 64: one access short of the end.
    step(37);
    check_val("e64 done", 32'(d_done), 32'd0);
    check_val("e64 acc",  32'(d_acc),  32'd31);
    // Edge 65: trace finished everywhere.
    step(1);
    check_dflt_final("dflt");
    check_val("p12 miss",   32'(a_miss),  32'd32);
    check_val("p12 hit",    32'(a_hit),   32'd0);
    check_val("p12 evict",  32'(a_evict), 32'd24);
    check_val("p12 done",   32'(a_done),  32'd1);
    check_val("p12w4 miss", 32'(b_miss),  32'd12);
    check_val("p12w4 hit",  32'(b_hit),   32'd20);
    check_val("p12w4 evict", 32'(b_evict), 32'd0);
    check_val("p12w4 acc",  32'(b_acc),   32'd32);
    check_val("s1 miss",    32'(s_miss),  32'd32);
    check_val("s1 hit",     32'(s_hit),   32'd0);
    check_val("s1 evict",   32'(s_evict), 32'd30);
    check_val("s1 done",    32'(s_done),  32'd1);
    check_val("inv hit+miss", 32'(d_hit) + 32'(d_miss), 32'd32);

    // DONE holds its outputs.
    step(100);
    check_dflt_final("hold");
    check_val("hold lhit", 32'(d_lhit), 32'd1);
    check_val("hold lway", 32'(d_lway), 32'd1);

    // Restart, then abort with an asynchronous reset after access 10.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    step(23);
    check_val("pre-abort acc", 32'(d_acc), 32'd11);
    #3;
    reset = 1'b1;
    #1;
    check_val("abort acc",  32'(d_acc),  32'd0);
    check_val("abort hit",  32'(d_hit),  32'd0);
    check_val("abort miss", 32'(d_miss), 32'd0);
    check_val("abort done", 32'(d_done), 32'd0);
    #2;
    reset = 1'b0;
    step(64);
    check_val("rerun e64 done", 32'(d_done), 32'd0);
    step(1);
    check_dflt_final("rerun");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
